// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_pkg
// Purpose  : Shared types and constants for the truth-table sweeper.
//            - tt_state_e : sweep controller states
//            - c_SETTLE_W : width of the settle down-counter
//            - rows(n)    : number of truth-table rows for n inputs
// Revision : 1.0  initial release
// ============================================================================
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  // Wide enough for SETTLE up to 15.
  localparam int c_SETTLE_W = 4;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tt_settle_ctr
// Purpose  : Loadable down-counter with zero flag; times how long the input
//            vector is held before the function output is sampled.
// Ports    : clk    in   rising-edge clock
//            rst_n  in   asynchronous active-low reset
//            load   in   load 'value' (has priority over dec)
//            dec    in   decrement by one; saturates at zero
//            value  in   load value
//            zero   out  counter is zero
// Revision : 1.0  initial release
// ============================================================================
module tt_settle_ctr
  import tt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  dec,
  input  logic [c_SETTLE_W-1:0] value,
  output logic                  zero
);

  logic [c_SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Synthesizable sequencer that walks an N_IN-input combinational
//            function through every input row, holds each row SETTLE cycles,
//            samples the function output and builds the truth table.
// Params   : N_IN    number of function inputs (1..6)
//            SETTLE  cycles each row is held before sampling (1..15)
// Ports    : clk, rst_n      clock, asynchronous active-low reset
//            start           begin a sweep (taken only in IDLE)
//            abort           stop a sweep; back to IDLE without done
//            f_i             output of the function under test
//            vec_o           input vector driven to the function
//            busy            controller not idle
//            done            one-cycle pulse when the table is complete
//            table_o         captured table; bit i = f(vec == i)
//            ones_o          number of rows where f = 1
// Macro    : EXPECT_CHECK_EN adds expect_i / mismatch_o / err_idx_o and a
//            per-row comparison against a golden table.
// Revision : 1.0  initial release
// ============================================================================
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_i,
`ifdef EXPECT_CHECK_EN
  input  logic [(1<<N_IN)-1:0]   expect_i,
  output logic                   mismatch_o,
  output logic [N_IN-1:0]        err_idx_o,
`endif
  output logic [N_IN-1:0]        vec_o,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_o,
  output logic [N_IN:0]          ones_o
);

  localparam int                    c_ROWS = rows(N_IN);
  localparam logic [c_SETTLE_W-1:0] c_LOAD = c_SETTLE_W'(SETTLE - 1);

  tt_state_e r_state;

  logic w_accept;     // start honoured this cycle
  logic w_sample_en;  // row is captured this cycle
  logic w_last;       // current row is the final one
  logic w_ctr_load;
  logic w_ctr_dec;
  logic w_settled;

  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_sample_en = (r_state == SAMPLE) && !abort;
  assign w_last      = (vec_o == N_IN'(c_ROWS - 1));
  assign w_ctr_load  = w_accept || (w_sample_en && !w_last);
  assign w_ctr_dec   = (r_state == DRIVE) && !abort;

  tt_settle_ctr u_settle_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_ctr_load),
    .dec   (w_ctr_dec),
    .value (c_LOAD),
    .zero  (w_settled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      vec_o   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_o <= '0;
      ones_o  <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= DRIVE;
            busy    <= 1'b1;
            vec_o   <= '0;
            table_o <= '0;
            ones_o  <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (w_settled) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            table_o[vec_o] <= f_i;
            ones_o         <= ones_o + {{N_IN{1'b0}}, f_i};
            // The last row exits to DONE, so vec_o never wraps.
            if (w_last) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              vec_o   <= vec_o + 1'b1;
              r_state <= DRIVE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXPECT_CHECK_EN
  logic [(1<<N_IN)-1:0] r_expect;
  logic                 r_err_seen;
  logic                 w_row_mis;

  assign w_row_mis = f_i ^ r_expect[vec_o];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expect   <= '0;
      r_err_seen <= 1'b0;
      mismatch_o <= 1'b0;
      err_idx_o  <= '0;
    end else if (w_accept) begin
      r_expect   <= expect_i;
      r_err_seen <= 1'b0;
      mismatch_o <= 1'b0;
      err_idx_o  <= '0;
    end else if (w_sample_en) begin
      // Rows are visited in ascending order, so the first miss is the lowest.
      if (w_row_mis && !r_err_seen) begin
        r_err_seen <= 1'b1;
        err_idx_o  <= vec_o;
      end
      // Flag is published together with the done pulse.
      if (w_last) begin
        mismatch_o <= r_err_seen | w_row_mis;
      end
    end
  end
`else
  // No golden-table comparator; the sweep core is unchanged.
`endif

endmodule
`default_nettype wire
